// File: rtl/heap_pkg.sv
// heap_pkg: constants and helpers shared by the heap sorter and its feeder.
// Contents: entry flag codes, feeder state encoding, heap size from level
// count, and the {flag, payload, key} entry packer.
package heap_pkg;
  localparam logic [1:0] FLAG_NORMAL = 2'b00;
  localparam logic [1:0] FLAG_MIN = 2'b01;
  localparam logic [1:0] FLAG_MAX = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_WAIT, ST_RUN, ST_FLUSH, ST_DRAIN} feed_state_t;
  function automatic int heap_size(input int nlevels);
    return (2 << nlevels) - 1;
  endfunction
  // Right-justified {flag, payload, key}; callers truncate to their entry width.
  function automatic logic [63:0] pack_entry(input logic [1:0] flag, input logic [63:0] payload,
                                             input logic [63:0] key, input int key_w, input int pay_w);
    logic [63:0] km, pm;
    km = (64'd1 << key_w) - 64'd1;
    pm = (64'd1 << pay_w) - 64'd1;
    return ({62'd0, flag} << (key_w + pay_w)) | ((payload & pm) << key_w) | (key & km);
  endfunction
endpackage

// File: rtl/heap_feed_gap.sv
// heap_feed_gap: loadable down-counter that stops at zero and flags it.
// Ports: clk, rstn (async, active-low), load/val (load a new count),
// zero (count has reached 0).
module heap_feed_gap #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/heap_feeder.sv
// heap_feeder: turns a per-frame valid/ready score stream into heap
// din/en/init/flush strobes, with insert spacing and per-frame init/flush/drain.
// Ports: clk, rstn (async, active-low); s_valid/s_ready/s_key/s_payload/s_sof/
// s_eof input stream; heap_din/heap_en/heap_init/heap_flush heap side;
// busy, frame_done (pulse), proto_err (sticky framing error).
// Build option HEAP_FEED_THRESH_EN adds thresh (keys below it are dropped)
// and drop_cnt (saturating per-frame drop count).
module heap_feeder import heap_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH = 16,
  parameter int NLEVELS = 2,
  parameter int ISSUE_GAP = 2,
  parameter int INIT_WAIT = 2
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [KEY_WIDTH-1:0]            s_key,
  input  logic [DATA_WIDTH-KEY_WIDTH-3:0] s_payload,
  input  logic                            s_sof,
  input  logic                            s_eof,
  output logic [DATA_WIDTH-1:0]           heap_din,
  output logic                            heap_en,
  output logic                            heap_init,
  output logic                            heap_flush,
  output logic                            busy,
  output logic                            frame_done,
`ifdef HEAP_FEED_THRESH_EN
  input  logic [KEY_WIDTH-1:0]            thresh,
  output logic [15:0]                     drop_cnt,
`endif
  output logic                            proto_err
);
  localparam int PW = DATA_WIDTH - 2 - KEY_WIDTH;
  localparam int DRAIN_LEN = 2 * heap_size(NLEVELS) + 4;
  localparam int GW = $clog2(ISSUE_GAP + 1);
  localparam int SW = $clog2(DRAIN_LEN + INIT_WAIT + 1);
  feed_state_t state;
  logic hold_valid, hold_eof, eof_sent;
  logic [KEY_WIDTH-1:0] hold_key;
  logic [PW-1:0] hold_pay;
  logic gap_zero, seq_zero, accept, keep_s, keep_h, issue_h, issue_s, seq_load;
  logic [SW-1:0] seq_val;
  assign busy = state != ST_IDLE;
  assign s_ready = state == ST_IDLE || (state == ST_RUN && gap_zero && !hold_valid && !eof_sent);
  assign accept = s_valid && s_ready;
`ifdef HEAP_FEED_THRESH_EN
  assign keep_s = s_key >= thresh;
  assign keep_h = hold_key >= thresh;
`else
  assign keep_s = 1'b1;
  assign keep_h = 1'b1;
`endif
  // The held sof beat issues on the WAIT->RUN edge so heap_en lands in the first RUN cycle.
  assign issue_h = state == ST_WAIT && seq_zero && keep_h;
  assign issue_s = state == ST_RUN && accept && keep_s;
  // One counter times both the post-init wait and the post-flush drain.
  assign seq_load = state == ST_INIT || (state == ST_FLUSH && gap_zero);
  assign seq_val = state == ST_INIT ? SW'(INIT_WAIT - 1) : SW'(DRAIN_LEN);
  heap_feed_gap #(.W(GW)) u_gap (
    .clk(clk), .rstn(rstn), .load(issue_h || issue_s), .val(GW'(ISSUE_GAP - 1)), .zero(gap_zero)
  );
  heap_feed_gap #(.W(SW)) u_seq (
    .clk(clk), .rstn(rstn), .load(seq_load), .val(seq_val), .zero(seq_zero)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= ST_IDLE;
      hold_valid <= 1'b0;
      hold_eof <= 1'b0;
      hold_key <= '0;
      hold_pay <= '0;
      eof_sent <= 1'b0;
      heap_din <= '0;
      heap_en <= 1'b0;
      heap_init <= 1'b0;
      heap_flush <= 1'b0;
      frame_done <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      heap_en <= issue_h || issue_s;
      heap_init <= state == ST_IDLE && accept && s_sof;
      heap_flush <= state == ST_FLUSH && gap_zero;
      frame_done <= state == ST_DRAIN && seq_zero;
      if (issue_h) heap_din <= DATA_WIDTH'(pack_entry(FLAG_NORMAL, 64'(hold_pay), 64'(hold_key), KEY_WIDTH, PW));
      else if (issue_s) heap_din <= DATA_WIDTH'(pack_entry(FLAG_NORMAL, 64'(s_payload), 64'(s_key), KEY_WIDTH, PW));
      if (accept && ((state == ST_IDLE && !s_sof) || (state == ST_RUN && s_sof))) proto_err <= 1'b1;
      case (state)
        ST_IDLE: if (accept && s_sof) begin
          state <= ST_INIT;
          hold_valid <= 1'b1;
          hold_key <= s_key;
          hold_pay <= s_payload;
          hold_eof <= s_eof;
          eof_sent <= 1'b0;
        end
        ST_INIT: state <= ST_WAIT;
        ST_WAIT: if (seq_zero) begin
          state <= ST_RUN;
          hold_valid <= 1'b0;
          eof_sent <= hold_eof;
        end
        ST_RUN: if (eof_sent) state <= ST_FLUSH;
          else if (accept) eof_sent <= s_eof;
        ST_FLUSH: if (gap_zero) state <= ST_DRAIN;
        ST_DRAIN: if (seq_zero) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
`ifdef HEAP_FEED_THRESH_EN
  logic drop;
  assign drop = (state == ST_WAIT && seq_zero && !keep_h) || (state == ST_RUN && accept && !keep_s);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) drop_cnt <= '0;
    else if (state == ST_DRAIN && seq_zero) drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hffff) drop_cnt <= drop_cnt + 16'd1;
`endif
endmodule

// File: doc/heap_feeder.md
Name: heap_feeder

Overview:
- Upstream stage of the one-cycle-delay heap sorter; converts a per-frame keypoint score stream (valid/ready) into the heap's din/en/init/flush protocol.
- Packs score and payload into the heap entry format (flag 2'b00 = normal), enforces the heap's minimum insert spacing and sequences per-frame init, flush and drain.
- Sits between the feature-score pipeline and the heap; the heap's dout/valid pass to consumers untouched.

Parameters:
- DATA_WIDTH, 32, heap entry width; must match heap.
- KEY_WIDTH, 16, score width; must match heap.
- NLEVELS, 2, heap levels; sets HEAP_SIZE = 2^(NLEVELS+1)-1.
- ISSUE_GAP, 2, minimum cycles between heap_en pulses (>=1).
- INIT_WAIT, 2, idle cycles after heap_init before first insert.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&s_ready.
- s_key  in  KEY_WIDTH  score.
- s_payload  in  DATA_WIDTH-2-KEY_WIDTH  coordinates/descriptor index.
- s_sof  in  1  first beat of frame.
- s_eof  in  1  last beat of frame.
- heap_din  out  DATA_WIDTH  {2'b00, payload, key}, registered.
- heap_en  out  1  one-cycle insert strobe.
- heap_init  out  1  one-cycle init strobe.
- heap_flush  out  1  one-cycle flush strobe.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse when drain completes.
- proto_err  out  1  sticky; set on framing violation, cleared only by reset.

Behaviour:
- Reset: all outputs 0, except s_ready = 1 (IDLE); state IDLE; counters and hold register cleared. Reset mid-frame abandons the frame, with no flush issued.
- FSM states: IDLE, INIT, WAIT, RUN, FLUSH, DRAIN.
- IDLE:
  - s_ready=1.
  - A beat with s_sof is captured into the hold register (eof bit kept), then go to INIT.
  - A beat without s_sof is discarded and sets proto_err.
- INIT: heap_init=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - INIT_WAIT cycles, then go to RUN.
  - On the first RUN cycle the held beat issues (heap_en=1, heap_din=held).
- RUN:
  - s_ready = (gap_cnt==0) && !hold_valid.
  - An accepted beat appears on heap_din with heap_en=1 on the next cycle (latency 1).
  - gap_cnt loads ISSUE_GAP-1 on each heap_en and counts down to 0, so heap_en pulses are at least ISSUE_GAP cycles apart.
  - An accepted beat with s_sof in RUN is inserted normally and sets proto_err.
- eof handling:
  - After the issue of an eof beat (held or streamed), go to FLUSH.
  - The sof&eof single-beat frame goes INIT, WAIT, RUN (one issue), FLUSH.
- FLUSH:
  - Wait until gap_cnt==0, then heap_flush=1 for one cycle.
  - Load drain_cnt = 2*HEAP_SIZE+4, go to DRAIN.
- DRAIN:
  - s_ready=0; drain_cnt decrements to 0.
  - Then frame_done=1 for one cycle and go to IDLE.
- heap_en, heap_init and heap_flush are mutually exclusive in every cycle.
- heap_din holds its last value when heap_en=0.

Optional Feature:
- Macro HEAP_FEED_THRESH_EN.
- Defined:
  - Adds input port thresh (KEY_WIDTH).
  - Accepted beats with s_key < thresh are consumed without an insert and without consuming gap.
  - eof/sof framing still applies: an eof beat below threshold still triggers FLUSH.
  - Adds output drop_cnt (16 bit, saturating), cleared on frame_done.
- Undefined: every accepted beat is inserted; no thresh or drop_cnt ports.

Decomposition:
- Shared package heap_pkg:
  - flag constants FLAG_NORMAL=2'b00, FLAG_MIN=2'b01, FLAG_MAX=2'b11.
  - HEAP_SIZE function of NLEVELS.
  - Entry pack function {flag, payload, key}.
- The heap sorter takes the same constants from heap_pkg.
- One sub-module, heap_feed_gap: the issue-spacing counter with load/zero flag, reused by the flush sequencer.

Test Plan:
- Reset, then one frame of 5 beats (keys 10,20,30,40,50; sof on first, eof on last; ISSUE_GAP=2) -> heap_init pulse; first heap_en at cycle 1+1+INIT_WAIT after sof accept; heap_en spacing exactly 2; heap_din[15:0] = 10..50 with flags 00; one heap_flush; frame_done after 2*7+4 drain cycles.
- s_valid held high continuously with ISSUE_GAP=3 -> s_ready duty 1/3; no beat lost or duplicated (payload sequence 0..15 matches).
- Single-beat frame (sof&eof, key 0x1234) -> init, one heap_en with din=0x00000000|…1234, flush, frame_done; busy low afterwards.
- Non-sof beat in IDLE, then sof beat in RUN -> proto_err set after first, stays 1; RUN sof beat still inserted.
- Reset asserted during DRAIN -> all strobes 0 immediately; s_ready=1; next sof frame proceeds normally.
- HEAP_FEED_THRESH_EN, thresh=25, keys 10,30,20,40(eof) -> heap_en only for 30,40; drop_cnt=2 before frame_done then 0.
